// File: rtl/display_scan.sv
// Four-digit multiplexed 7-segment scanner with sequential binary-to-BCD
// conversion, saturation flag and leading-zero blanking.
module display_scan #(
  parameter int REFRESH_DIV = 100000,
  parameter int MAX_VAL     = 9999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [13:0] value,
  output logic        busy,
  output logic        ovf,
  output logic [3:0]  num,
  output logic [3:0]  an
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [13:0] MAXV = 14'(MAX_VAL);
  localparam logic [PW-1:0] PLAST = PW'(REFRESH_DIV - 1);

  typedef enum logic {IDLE, CONV} state_t;

  state_t         state_q;
  logic [3:0]     cnt_q;
  logic [13:0]    bin_q;
  logic [15:0]    bcd_q;
  logic           ovfc_q;
  logic           busy_q;
  logic           ovf_q;
  logic [15:0]    disp_q;
  logic [PW-1:0]  presc_q;
  logic [1:0]     idx_q;

  logic [15:0]    adj;
  logic [15:0]    bcd_d;
  logic [13:0]    bin_d;
  logic           sat;

  assign sat = (value > MAXV);

  // add-3 on every nibble >= 5, then shift one binary bit into the BCD field
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    bcd_d = {adj[14:0], bin_q[13]};
    bin_d = {bin_q[12:0], 1'b0};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
      ovfc_q  <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
      disp_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (load) begin
            bin_q   <= sat ? MAXV : value;
            bcd_q   <= '0;
            cnt_q   <= '0;
            ovfc_q  <= sat;
            busy_q  <= 1'b1;
            state_q <= CONV;
          end
        end
        CONV: begin
          bcd_q <= bcd_d;
          bin_q <= bin_d;
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd13) begin
            disp_q  <= bcd_d;
            ovf_q   <= ovfc_q;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      idx_q   <= '0;
    end else if (presc_q == PLAST) begin
      presc_q <= '0;
      idx_q   <= idx_q + 2'd1;
    end else begin
      presc_q <= presc_q + PW'(1);
    end
  end

  logic [3:0] lead;

  always_comb begin
    lead[3] = (disp_q[15:12] == 4'd0);
    lead[2] = lead[3] & (disp_q[11:8] == 4'd0);
    lead[1] = lead[2] & (disp_q[7:4] == 4'd0);
    lead[0] = 1'b0;
    num = 4'd0;
    an  = 4'b1111;
    unique case (idx_q)
      2'd0: num = disp_q[3:0];
      2'd1: num = disp_q[7:4];
      2'd2: num = disp_q[11:8];
      2'd3: num = disp_q[15:12];
      default: num = 4'd0;
    endcase
    if (!lead[idx_q])
      an = ~(4'b0001 << idx_q);
  end

  assign busy = busy_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_display_scan.sv
// Scoreboard bench for display_scan: loads push expected digits,
// each completed conversion is popped and checked over a full scan round.
module tb_display_scan;

  typedef struct {
    logic [15:0] d;
    logic        o;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [13:0] value = '0;
  logic        busy, ovf;
  logic [3:0]  num, an;

  int n_vec = 0;
  int n_err = 0;
  exp_t sb[$];
  exp_t cur;
  logic [31:0] m_cnt;

  display_scan #(.REFRESH_DIV(4), .MAX_VAL(9999)) dut (
    .clk(clk), .rst(rst), .load(load), .value(value),
    .busy(busy), .ovf(ovf), .num(num), .an(an)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) m_cnt <= 0;
    else m_cnt <= m_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got %0d want %0d", tag, got, want);
    end
  endtask

  function automatic exp_t mk(input int v);
    exp_t e;
    int s;
    s = (v > 9999) ? 9999 : v;
    e.d[3:0]   = 4'(s % 10);
    e.d[7:4]   = 4'((s / 10) % 10);
    e.d[11:8]  = 4'((s / 100) % 10);
    e.d[15:12] = 4'((s / 1000) % 10);
    e.o = (v > 9999);
    return e;
  endfunction

  function automatic logic [3:0] exp_an(input exp_t e, input int i);
    logic blank;
    blank = 1'b0;
    if (i > 0) blank = ((e.d >> (4 * i)) == 16'd0);
    return blank ? 4'b1111 : ~(4'b0001 << i);
  endfunction

  task automatic scan_chk(input exp_t e);
    int i;
    for (int k = 0; k < 16; k++) begin
      if (k > 0) @(negedge clk);
      i = int'(m_cnt[3:2]);
      chk("num", num, e.d[4*i +: 4]);
      chk("an", an, exp_an(e, i));
    end
    chk("ovf", ovf, e.o);
  endtask

  task automatic start(input int v);
    load = 1'b1;
    value = 14'(v);
    sb.push_back(mk(v));
  endtask

  task automatic finish(input bit inject);
    int n;
    int i;
    exp_t e;
    @(posedge clk);
    #1 load = 1'b0;
    chk("busy_rise", busy, 1);
    n = 0;
    do begin
      @(negedge clk);
      load = 1'b0;
      if (busy) n++;
      if (n == 7 && busy) begin
        i = int'(m_cnt[3:2]);
        chk("hold_num", num, cur.d[4*i +: 4]);
        if (inject) begin
          load = 1'b1;
          value = 14'd5678;
        end
      end
    end while (busy && n < 40);
    chk("busy_len", n, 14);
    chk("sb_depth", sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      cur = e;
      scan_chk(e);
    end
  endtask

  initial begin
    cur.d = '0;
    cur.o = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_num", num, 0);
    chk("rst_an", an, 4'b1110);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    scan_chk(cur);

    @(negedge clk); start(1234);  finish(0);
    @(negedge clk); start(42);    finish(0);
    @(negedge clk); start(0);     finish(0);
    @(negedge clk); start(12000); finish(0);
    @(negedge clk); start(5);     finish(0);
    @(negedge clk); start(1234);  finish(1);

    @(negedge clk);
    load = 1'b1;
    value = 14'd9999;
    @(posedge clk);
    #1 load = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_ovf", ovf, 0);
    chk("abort_num", num, 0);
    chk("abort_an", an, 4'b1110);
    cur.d = '0;
    cur.o = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    start(77);
    finish(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
